// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared state encoding and line constants for fifo_uart_tx
//
// Purpose: state enum for the FIFO-draining serial transmitter and the idle
// level of the serial line.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  // Level of the serial line when no frame is in flight (also the stop bit).
  localparam logic TX_IDLE = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - per-bit clock divider for the serial transmitter
//
// Purpose: counts CLKS_PER_BIT cycles per serial bit.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   clear in  hold the counter at zero (between frames and at frame load)
//   tick  out high on the last cycle of each bit period
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // With CLKS_PER_BIT=1 the counter sits at zero and tick is high every
  // cycle that clear is low.
  assign tick = !clear && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains a sync FIFO onto an async serial line
//
// Purpose: pops one word at a time from a 1-cycle-latency FIFO and sends it
// as start bit, DATA_W data bits LSB first, stop bit.
// Ports:
//   clk         in  system clock
//   rst         in  synchronous active-high reset
//   fifo_empty  in  FIFO empty flag, sampled only in IDLE
//   fifo_data   in  FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  out one-cycle pop pulse per word
//   tx          out serial line, idles high
//   busy        out high from fetch through the stop bit
//   byte_done   out one-cycle pulse in the first IDLE cycle after a frame
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              byte_done
);

  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [IDX_W-1:0]  idx_q;
  logic              tx_q;
  logic              rd_en_q;
  logic              busy_q;
  logic              done_q;

  logic bit_clear;
  logic bit_tick;

  // Timer only runs while a bit is on the line; held cleared otherwise so
  // the start bit always gets a full period.
  assign bit_clear = (state_q == IDLE) || (state_q == FETCH) || (state_q == LOAD);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(bit_clear),
    .tick (bit_tick)
  );

  assign shift_d = shift_q >> 1;

  // Outputs are registered one cycle ahead of the state they belong to, so
  // each is loaded on the transition into that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= TX_IDLE;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q <= FETCH;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          state_q <= LOAD;
        end
        LOAD: begin
          shift_q <= fifo_data;
          idx_q   <= '0;
          tx_q    <= ~TX_IDLE;
          state_q <= START;
        end
        START: begin
          if (bit_tick) begin
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            shift_q <= shift_d;
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              tx_q    <= TX_IDLE;
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              tx_q  <= shift_d[0];
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          tx_q    <= TX_IDLE;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign byte_done  = done_q;

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for `sync_fifo`. Pops one word at a time when the FIFO is non-empty and transmits it as an asynchronous serial frame on `tx`: one start bit, DATA_W data bits LSB first, and one stop bit. It consumes the FIFO's `empty`/`data_out` outputs and drives its `rd_en`, so the FIFO becomes the transmit buffer of a simple UART-style link.

## Interface
- DATA_W, 8, word width; must match the FIFO data width.
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range is ≥1.

- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- fifo_empty  in  1  FIFO `empty` flag.
- fifo_data  in  DATA_W  FIFO `data_out`; valid in the cycle after `fifo_rd_en`, because the FIFO read has 1-cycle latency.
- fifo_rd_en  out  1  FIFO `rd_en`; single-cycle pulse per popped word.
- tx  out  1  serial line; idles high.
- busy  out  1  high from fetch through the stop bit.
- byte_done  out  1  one-cycle pulse after each complete frame.

## Operation
- The FSM has these states: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE:
  - If `fifo_empty` is 0, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - `fifo_rd_en`=1 for exactly this cycle.
  - Always go to LOAD.
- LOAD:
  - Capture `fifo_data` into the shift register.
  - Clear the bit-timer and the bit index.
  - Go to START.
- START:
  - `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - `tx` = shift register bit 0.
  - After each CLKS_PER_BIT cycles, shift right and increment the bit index.
  - After DATA_W bits, go to STOP.
- STOP:
  - `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Output assignment:
  - `busy`=1 in every state except IDLE.
  - `byte_done`=1 in the first IDLE cycle after STOP.
- `fifo_rd_en` is asserted only from FETCH, and FETCH is entered only when `fifo_empty`=0. The block never pops an empty FIFO.
- `fifo_empty` is ignored outside IDLE.
- Bit-timer width is clog2(CLKS_PER_BIT), with a minimum of 1. Bit-index width is clog2(DATA_W+1).
- Both counters are unsigned, count up, and reset to 0 at each bit or frame boundary. They never wrap mid-bit.
- Reset mid-frame:
  - The next cycle is IDLE with `tx`=1, `busy`=0, `byte_done`=0, `fifo_rd_en`=0.
  - The in-flight word is discarded; it was already popped and is not retried.
  - The next non-empty FIFO word starts a fresh frame.

## Timing
- Reset values: `tx`=1, `fifo_rd_en`=0, `busy`=0, `byte_done`=0, state IDLE, shift register 0.
- All outputs are registered or pure Moore decodes of state; there are no combinational paths from inputs to outputs.
- Relative to cycle n, the first IDLE cycle that samples `fifo_empty`=0:
  - FETCH: n+1.
  - LOAD: n+2.
  - Start bit: n+3 … n+2+CLKS_PER_BIT.
  - Data bit k: n+3+(k+1)·CLKS_PER_BIT onward.
  - Stop bit: ends at n+2+(DATA_W+2)·CLKS_PER_BIT.
  - `byte_done`: the cycle after the stop bit ends.
- Frame length on `tx` is (DATA_W+2)·CLKS_PER_BIT cycles.
- Back-to-back words: start-bit-to-start-bit spacing is (DATA_W+2)·CLKS_PER_BIT + 3 cycles, because the IDLE cycle carrying `byte_done` also samples `fifo_empty`.
- Simultaneous writes to the FIFO while draining need no special handling; the FIFO owns the full and empty accounting.

## Structure
- Package `fifo_uart_pkg`: state enum (IDLE, FETCH, LOAD, START, DATA, STOP) and the `TX_IDLE`=1 line-level constant.
- One sub-module, `bit_timer`: CLKS_PER_BIT counter with `clear` input and `tick` output, where `tick` is high on the last cycle of each bit period. The FSM and shift register stay in `fifo_uart_tx`.

## Test plan
Defaults are DATA_W=8 and CLKS_PER_BIT=4, chained to `sync_fifo`.
- **Reset:** hold `rst`=1 for 2 cycles with `fifo_empty`=1 → `tx`=1, `fifo_rd_en`=0, `busy`=0, `byte_done`=0. These values persist while the FIFO stays empty.
- **Single word:** write 0xA5 into the FIFO.
  - IDLE sees non-empty at cycle 0, so `fifo_rd_en` pulses at cycle 1.
  - `tx`=0 over cycles 3–6.
  - Data bits 1,0,1,0,0,1,0,1, 4 cycles each, over cycles 7–38.
  - `tx`=1 over cycles 39–42.
  - `byte_done` at cycle 43.
- **Burst:** fill the FIFO with 0x00…0x07 until `full` → 8 `fifo_rd_en` pulses spaced 43 cycles apart. Frames decode in order 0x00…0x07, `empty` is seen after the eighth pop, and there is no ninth `fifo_rd_en`.
- **Reset mid-data:** assert `rst` during bit 3 of 0x3C with 0x81 queued behind it → `tx`=1 and `busy`=0 the next cycle, and no `byte_done`. After reset the next frame carries 0x81.
- **Fast rate:** with CLKS_PER_BIT=1, send 0xFF then 0x00 → 10-cycle frames with start spacing 13. The 0x00 frame holds `tx`=0 for 9 consecutive cycles (start bit plus 8 data bits).
